// File: rtl/prog_loader_if.sv
// Byte-stream source and instruction-memory write port of the program loader.
// slave: loader side; master: byte source / memory / CPU-control side.
interface prog_loader_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 5
);
  logic                     byte_valid;
  logic [7:0]               byte_data;
  logic                     byte_ready;
  logic                     mem_we;
  logic [ADDRESS_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0]    mem_wd;
  logic                     cpu_rst;
  logic                     done;
  logic                     err;

  modport slave (
    input  byte_valid, byte_data,
    output byte_ready, mem_we, mem_addr, mem_wd, cpu_rst, done, err
  );

  modport master (
    output byte_valid, byte_data,
    input  byte_ready, mem_we, mem_addr, mem_wd, cpu_rst, done, err
  );
endinterface

// File: rtl/prog_loader.sv
// Loads a framed program image (A5, N, 4N bytes, XOR checksum) into instruction
// memory and releases the CPU from reset once the image checks out.
//
// state | meaning
// IDLE  | hunting for the 0xA5 header, other bytes dropped
// LEN   | waiting for the word count N
// DATA  | assembling a little-endian word, folding bytes into the checksum
// WRITE | one-cycle memory write of the assembled word
// CHK   | comparing the received checksum byte
// DONE  | image loaded, CPU released (terminal)
// ERR   | load aborted, CPU held in reset (terminal)
module prog_loader #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 5
) (
  input  logic          CLK,
  input  logic          RST,
  prog_loader_if.slave  bus
);
  localparam int MAX_WORDS = 2 ** (ADDRESS_WIDTH - 2);
  localparam int IDXW      = ADDRESS_WIDTH - 1;
  localparam logic [8:0] MAX_W9 = 9'(MAX_WORDS);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN, S_DATA, S_WRITE, S_CHK, S_DONE, S_ERR
  } state_e;

  state_e                   state_q, state_d;
  logic [1:0]               byte_cnt_q, byte_cnt_d;
  logic [IDXW-1:0]          word_idx_q, word_idx_d;
  logic [IDXW-1:0]          len_q, len_d;
  logic [7:0]               chk_q, chk_d;
  logic [DATA_WIDTH-1:0]    word_q, word_d;
  logic [ADDRESS_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0]    mem_wd_q, mem_wd_d;

  logic ready_state;
  logic accept;
  logic len_ok;

  assign ready_state = (state_q == S_IDLE) || (state_q == S_LEN) ||
                       (state_q == S_DATA) || (state_q == S_CHK);
  assign accept      = bus.byte_valid && ready_state && !RST;
  assign len_ok      = (bus.byte_data != 8'd0) && ({1'b0, bus.byte_data} <= MAX_W9);

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    word_idx_d = word_idx_q;
    len_d      = len_q;
    chk_d      = chk_q;
    word_d     = word_q;
    mem_addr_d = mem_addr_q;
    mem_wd_d   = mem_wd_q;
    case (state_q)
      S_IDLE: begin
        if (accept && bus.byte_data == 8'hA5) begin
          state_d    = S_LEN;
          byte_cnt_d = 2'd0;
          word_idx_d = '0;
          chk_d      = 8'd0;
        end
      end
      S_LEN: begin
        if (accept) begin
          if (len_ok) begin
            len_d   = IDXW'(bus.byte_data);
            state_d = S_DATA;
          end else begin
            state_d = S_ERR;
          end
        end
      end
      S_DATA: begin
        if (accept) begin
          // new byte enters at the top, so after four bytes the first sits in [7:0]
          word_d     = {bus.byte_data, word_q[DATA_WIDTH-1:8]};
          chk_d      = chk_q ^ bus.byte_data;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            state_d    = S_WRITE;
            mem_addr_d = {word_idx_q[ADDRESS_WIDTH-3:0], 2'b00};
            mem_wd_d   = word_d;
          end
        end
      end
      S_WRITE: begin
        word_idx_d = word_idx_q + 1'b1;
        state_d    = (word_idx_d == len_q) ? S_CHK : S_DATA;
      end
      S_CHK: begin
        if (accept) begin
          state_d = (bus.byte_data == chk_q) ? S_DONE : S_ERR;
        end
      end
      S_DONE:  state_d = S_DONE;
      S_ERR:   state_d = S_ERR;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= S_IDLE;
      byte_cnt_q <= 2'd0;
      word_idx_q <= '0;
      len_q      <= '0;
      chk_q      <= 8'd0;
      word_q     <= '0;
      mem_addr_q <= '0;
      mem_wd_q   <= '0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      word_idx_q <= word_idx_d;
      len_q      <= len_d;
      chk_q      <= chk_d;
      word_q     <= word_d;
      mem_addr_q <= mem_addr_d;
      mem_wd_q   <= mem_wd_d;
    end
  end

  assign bus.byte_ready = ready_state && !RST;
  assign bus.mem_we     = (state_q == S_WRITE);
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wd     = mem_wd_q;
  assign bus.cpu_rst    = (state_q != S_DONE);
  assign bus.done       = (state_q == S_DONE);
  assign bus.err        = (state_q == S_ERR);
endmodule

// File: tb/tb_prog_loader.sv
// Directed frames into prog_loader; expected memory writes go to a scoreboard
// queue that a negedge monitor drains whenever mem_we is seen.
module tb_prog_loader;
  localparam int DW = 32;
  localparam int AW = 5;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  wr_t  exp_q[$];
  wr_t  mon_e;

  prog_loader_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) bus ();

  prog_loader #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // scoreboard monitor: every write must match the oldest expected write
  always @(negedge clk) begin
    if (!rst && bus.mem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write actual addr=%h data=%h required=none",
                 bus.mem_addr, bus.mem_wd);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_addr", 32'(bus.mem_addr), 32'(mon_e.addr));
        check("wr_data", bus.mem_wd, mon_e.data);
        check("wr_ready_low", 32'(bus.byte_ready), 32'd0);
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 32'(bus.byte_ready), 32'd0);
    check("rst_cpu_rst", 32'(bus.cpu_rst), 32'd1);
    check("rst_done_err", {30'd0, bus.done, bus.err}, 32'd0);
    check("rst_mem", {31'd0, bus.mem_we} | 32'(bus.mem_addr) | bus.mem_wd, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("idle_ready", 32'(bus.byte_ready), 32'd1);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit acc;
    int n;
    for (int g = 0; g < gap; g++) begin
      bus.byte_valid = 1'b0;
      bus.byte_data  = 8'($urandom);
      @(posedge clk);
      #1;
    end
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 64) begin
      acc = bus.byte_ready;
      @(posedge clk);
      #1;
      n++;
    end
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h5A;
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL send_timeout actual=not_accepted required=accepted byte=%h", b);
    end
  endtask

  task automatic expect_terminal(input string tag, input bit ok);
    check({tag, "_done"}, 32'(bus.done), ok ? 32'd1 : 32'd0);
    check({tag, "_err"}, 32'(bus.err), ok ? 32'd0 : 32'd1);
    check({tag, "_cpu_rst"}, 32'(bus.cpu_rst), ok ? 32'd0 : 32'd1);
    check({tag, "_ready"}, 32'(bus.byte_ready), 32'd0);
  endtask

  initial begin
    logic [7:0]  b;
    logic [7:0]  cs;
    logic [31:0] w;
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;

    // single-word frame, done visible the cycle after the checksum
    do_reset();
    exp_q.push_back('{addr: 5'h00, data: 32'h12345678});
    send_byte(8'hA5, 0); send_byte(8'h01, 0);
    send_byte(8'h78, 0); send_byte(8'h56, 0); send_byte(8'h34, 0); send_byte(8'h12, 0);
    check("t1_done_before_chk", 32'(bus.done), 32'd0);
    send_byte(8'h08, 0);
    expect_terminal("t1", 1'b1);
    bus.byte_valid = 1'b1;
    bus.byte_data  = 8'hA5;
    repeat (4) @(posedge clk);
    #1;
    bus.byte_valid = 1'b0;
    check("t1_done_sticky", 32'(bus.done), 32'd1);
    check("t1_writes_seen", 32'(exp_q.size()), 32'd0);

    // garbage before the header is dropped
    do_reset();
    send_byte(8'h00, 0); send_byte(8'hFF, 1); send_byte(8'h3C, 0);
    check("t2_idle_ready", 32'(bus.byte_ready), 32'd1);
    exp_q.push_back('{addr: 5'h00, data: 32'h44332211});
    send_byte(8'hA5, 0); send_byte(8'h01, 0);
    send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h33, 0); send_byte(8'h44, 0);
    send_byte(8'h44, 0);
    expect_terminal("t2", 1'b1);

    // illegal counts
    do_reset();
    send_byte(8'hA5, 0); send_byte(8'h00, 0);
    expect_terminal("t3_len0", 1'b0);
    do_reset();
    send_byte(8'hA5, 0); send_byte(8'h09, 0);
    expect_terminal("t3_len9", 1'b0);

    // bad checksum: word stays written, then error
    do_reset();
    exp_q.push_back('{addr: 5'h00, data: 32'h12345678});
    send_byte(8'hA5, 0); send_byte(8'h01, 0);
    send_byte(8'h78, 0); send_byte(8'h56, 0); send_byte(8'h34, 0); send_byte(8'h12, 0);
    send_byte(8'h09, 0);
    expect_terminal("t4", 1'b0);
    check("t4_writes_seen", 32'(exp_q.size()), 32'd0);

    // full eight-word image with random valid gaps
    do_reset();
    send_byte(8'hA5, $urandom_range(0, 3));
    send_byte(8'h08, $urandom_range(0, 3));
    cs = 8'h00;
    for (int i = 0; i < 8; i++) begin
      w = 32'h0;
      for (int j = 0; j < 4; j++) begin
        b = 8'(i * 16 + j * 3 + 1);
        w[j*8 +: 8] = b;
        cs = cs ^ b;
      end
      exp_q.push_back('{addr: 5'(i * 4), data: w});
      for (int j = 0; j < 4; j++) send_byte(w[j*8 +: 8], $urandom_range(0, 3));
    end
    check("t5_done_before_chk", 32'(bus.done), 32'd0);
    send_byte(cs, $urandom_range(0, 3));
    expect_terminal("t5", 1'b1);
    check("t5_writes_seen", 32'(exp_q.size()), 32'd0);

    // reset mid-frame, next frame restarts at address 0
    do_reset();
    exp_q.push_back('{addr: 5'h00, data: 32'h04030201});
    send_byte(8'hA5, 0); send_byte(8'h02, 0);
    send_byte(8'h01, 0); send_byte(8'h02, 0); send_byte(8'h03, 0); send_byte(8'h04, 0);
    send_byte(8'h05, 0); send_byte(8'h06, 0);
    do_reset();
    check("t6_first_write_seen", 32'(exp_q.size()), 32'd0);
    exp_q.push_back('{addr: 5'h00, data: 32'hDEADBEEF});
    send_byte(8'hA5, 0); send_byte(8'h01, 0);
    send_byte(8'hEF, 0); send_byte(8'hBE, 0); send_byte(8'hAD, 0); send_byte(8'hDE, 0);
    send_byte(8'h22, 0);
    expect_terminal("t6", 1'b1);

    repeat (4) @(posedge clk);
    #1;
    check("final_writes_seen", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, instruction word width (fixed at 32 for this protocol).
REQ-002 SHALL have parameter ADDRESS_WIDTH, default 5, byte-address width of the instruction memory (legal range 3..10).
REQ-003 SHALL derive MAX_WORDS = 2^(ADDRESS_WIDTH-2), the instruction memory capacity in words.
REQ-004 SHALL have port CLK  input  1  clock; one clock, all state updates on its rising edge.
REQ-005 SHALL have port RST  input  1  reset; synchronous, active-high.
REQ-006 SHALL have port byte_valid  input  1  the source presents a byte.
REQ-007 SHALL have port byte_data  input  8  byte from the source.
REQ-008 SHALL have port byte_ready  output  1  the loader accepts a byte this cycle.
REQ-009 SHALL have port mem_we  output  1  instruction memory write strobe.
REQ-010 SHALL have port mem_addr  output  ADDRESS_WIDTH  instruction memory byte address, word-aligned.
REQ-011 SHALL have port mem_wd  output  DATA_WIDTH  instruction word to write.
REQ-012 SHALL have port cpu_rst  output  1  holds the CPU in reset while high.
REQ-013 SHALL have port done  output  1  image loaded and verified.
REQ-014 SHALL have port err  output  1  load aborted.

Function
REQ-015 SHALL accept a byte only in a cycle where byte_valid and byte_ready are both 1; byte_data is ignored in all other cycles.
REQ-016 SHALL use the frame format 0xA5 header, count byte N (words), 4N data bytes, checksum byte (XOR of the 4N data bytes).
REQ-017 SHALL implement the states IDLE, LEN, DATA, WRITE, CHK, DONE and ERR.
REQ-018 SHALL drive byte_ready=1 in IDLE, LEN, DATA and CHK, and byte_ready=0 in WRITE, DONE and ERR; byte_ready is decoded from the state.
REQ-019 IDLE: an accepted 0xA5 SHALL move the block to LEN; any other accepted byte SHALL be discarded and the block SHALL stay in IDLE.
REQ-020 LEN: an accepted N with 1 <= N <= MAX_WORDS SHALL latch N and move the block to DATA; N=0 or N>MAX_WORDS SHALL move the block to ERR.
REQ-021 DATA: the block SHALL assemble bytes little-endian, so the first byte of each group of four lands in [7:0] and the fourth in [31:24].
REQ-022 DATA: each accepted data byte SHALL be XORed into an 8-bit running checksum.
REQ-023 When the 4th byte of a word is accepted in cycle t, the block SHALL enter WRITE and, in cycle t+1, drive mem_we=1, mem_addr=4*word_index and mem_wd=the assembled word.
REQ-024 WRITE SHALL last exactly one cycle; the block SHALL then go to DATA, or to CHK if word_index+1 = N, and word_index SHALL increment by 1.
REQ-025 mem_we SHALL be 1 only in WRITE; mem_addr and mem_wd SHALL hold their last values outside WRITE.
REQ-026 mem_addr SHALL never exceed 4*(MAX_WORDS-1) and SHALL never wrap within one frame.
REQ-027 CHK: an accepted byte equal to the running checksum SHALL move the block to DONE; any other value SHALL move it to ERR.
REQ-028 Words already written before a checksum or length error SHALL remain in memory; the block SHALL issue no rollback writes.
REQ-029 DONE SHALL be a terminal state with done=1 and cpu_rst=0, first visible in the cycle after the checksum byte is accepted.
REQ-030 ERR SHALL be a terminal state with err=1 and cpu_rst=1.
REQ-031 In every state other than DONE, cpu_rst SHALL be 1.
REQ-032 A byte_valid gap of any length SHALL stall the block without changing its state, counters or checksum.
REQ-033 The block SHALL have no timeout; only RST leaves DONE or ERR.

Reset
REQ-034 While RST=1 at a clock edge, the block SHALL set the state to IDLE and clear the byte count, word_index and checksum to 0.
REQ-035 While RST=1 at a clock edge, the block SHALL set mem_we=0, mem_addr=0, mem_wd=0, cpu_rst=1, done=0 and err=0.
REQ-036 While RST=1, byte_ready SHALL be forced to 0.
REQ-037 RST in the middle of a frame SHALL abandon the frame; the next frame SHALL start writing at address 0, and memory contents are not cleared.

Verification
REQ-038 Stream A5,01,78,56,34,12,08 -> exactly one mem_we, with mem_addr=0x00 and mem_wd=0x12345678; done=1 and cpu_rst=0 one cycle after 08 is accepted.
REQ-039 Stream 00,FF,3C then A5,01,... -> no writes and no state change until A5; the frame then loads normally.
REQ-040 Count byte 00 or 09 (ADDRESS_WIDTH=5) -> err=1, mem_we never asserted, cpu_rst stays 1, byte_ready=0.
REQ-041 Valid single-word frame with checksum 09 instead of 08 -> the word is written at 0x00, then err=1 and done=0.
REQ-042 Eight-word frame with random byte_valid gaps -> writes at 0x00,0x04,...,0x1C in order, byte_ready=0 in each WRITE cycle, and done=1 at the end.
REQ-043 RST pulsed after 6 data bytes, then a new 1-word frame -> the new write lands at 0x00 with the correct word, and done=1.
